// File: rtl/clock_sequencer_if.sv
// ----------------------------------------------------------------------------
// clock_sequencer_if
// Groups the control/configuration inputs and the generated clock/tick
// outputs of clock_sequencer into one bundle.
//   master : drives enable, mode, step_req, cfg_load, div_ratio, phase;
//            observes clk_out, tick, busy, cycle_count
//   slave  : the sequencer itself (mirror of master)
// div_ratio / phase pack channel i in bits [i*CNT_W +: CNT_W].
// ----------------------------------------------------------------------------
interface clock_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic                      enable;
    logic                      mode;
    logic                      step_req;
    logic                      cfg_load;
    logic [NUM_CH*CNT_W-1:0]   div_ratio;
    logic [NUM_CH*CNT_W-1:0]   phase;
    logic [NUM_CH-1:0]         clk_out;
    logic [NUM_CH-1:0]         tick;
    logic                      busy;
    logic [31:0]               cycle_count;

    modport master (
        output enable, mode, step_req, cfg_load, div_ratio, phase,
        input  clk_out, tick, busy, cycle_count
    );

    modport slave (
        input  enable, mode, step_req, cfg_load, div_ratio, phase,
        output clk_out, tick, busy, cycle_count
    );
endinterface

// File: rtl/clock_sequencer.sv
// ----------------------------------------------------------------------------
// clock_sequencer
// Generates NUM_CH divided clocks and one-cycle tick enables from the master
// clock. Each channel has a runtime divide ratio R and tick phase P, latched on
// cfg_load (which also realigns every channel). Supports freeze (enable=0),
// single-step debug (mode=1 + step_req) and a 32-bit channel-0 tick counter.
// Ports:
//   clock : master clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : clock_sequencer_if.slave (controls, config, clk_out/tick/busy/
//           cycle_count, all outputs registered)
// ----------------------------------------------------------------------------
module clock_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    clock_sequencer_if.slave     bus
);

    localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

    // Single-step window: ST_STEP is the open window (busy).
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } step_state_t;

    step_state_t                    state_r;
    logic [NUM_CH-1:0][CNT_W-1:0]   ratio_r;
    logic [NUM_CH-1:0][CNT_W-1:0]   phase_r;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_r;
    logic [NUM_CH-1:0]              clk_out_r;
    logic [NUM_CH-1:0]              tick_r;
    logic [31:0]                    cycle_count_r;

    logic [NUM_CH-1:0][CNT_W-1:0]   ld_ratio_s;
    logic [NUM_CH-1:0][CNT_W-1:0]   ld_phase_s;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_n_s;
    logic [NUM_CH-1:0]              tick_n_s;
    logic [NUM_CH-1:0]              clk_n_s;
    logic                           busy_s;
    logic                           adv_s;

    assign busy_s = (state_r == ST_STEP);
    // In free-run every enabled edge advances; in step mode only inside the window.
    assign adv_s  = bus.enable & (~bus.mode | busy_s);

    // Sanitised config to latch, and per-channel next count / tick / clock level.
    always_comb begin
        ld_ratio_s = {NUM_CH{ZERO}};
        ld_phase_s = {NUM_CH{ZERO}};
        cnt_n_s    = {NUM_CH{ZERO}};
        tick_n_s   = {NUM_CH{1'b0}};
        clk_n_s    = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            // A zero ratio would never wrap; treat it as divide-by-1.
            if (bus.div_ratio[i*CNT_W +: CNT_W] == ZERO) begin
                ld_ratio_s[i] = ONE;
            end else begin
                ld_ratio_s[i] = bus.div_ratio[i*CNT_W +: CNT_W];
            end
            // An unreachable phase is clamped to the last count so the tick still fires.
            if (bus.phase[i*CNT_W +: CNT_W] >= ld_ratio_s[i]) begin
                ld_phase_s[i] = ld_ratio_s[i] - ONE;
            end else begin
                ld_phase_s[i] = bus.phase[i*CNT_W +: CNT_W];
            end
            if (cnt_r[i] == ratio_r[i] - ONE) begin
                cnt_n_s[i] = ZERO;
            end else begin
                cnt_n_s[i] = cnt_r[i] + ONE;
            end
            tick_n_s[i] = (cnt_n_s[i] == phase_r[i]);
            // Odd ratios are high for floor(R/2) counts; R==1 is a constant-high clock.
            if (ratio_r[i] == ONE) begin
                clk_n_s[i] = 1'b1;
            end else begin
                clk_n_s[i] = (cnt_n_s[i] < (ratio_r[i] >> 1));
            end
        end
    end

    // Channel counters, outputs, tick counter and single-step window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ratio_r[i] <= DIV_INIT;
                phase_r[i] <= ZERO;
                cnt_r[i]   <= DIV_INIT - ONE;
            end
            clk_out_r     <= {NUM_CH{1'b0}};
            tick_r        <= {NUM_CH{1'b0}};
            cycle_count_r <= 32'd0;
            state_r       <= ST_IDLE;
        end else if (bus.cfg_load) begin
            // Counters park at R-1 so the next advancing edge looks like the first after reset.
            for (int i = 0; i < NUM_CH; i++) begin
                ratio_r[i] <= ld_ratio_s[i];
                phase_r[i] <= ld_phase_s[i];
                cnt_r[i]   <= ld_ratio_s[i] - ONE;
            end
            clk_out_r     <= {NUM_CH{1'b0}};
            tick_r        <= {NUM_CH{1'b0}};
            cycle_count_r <= 32'd0;
            state_r       <= ST_IDLE;
        end else begin
            if (adv_s) begin
                cnt_r     <= cnt_n_s;
                tick_r    <= tick_n_s;
                clk_out_r <= clk_n_s;
                if (tick_n_s[0]) begin
                    cycle_count_r <= cycle_count_r + 32'd1;
                end else begin
                    cycle_count_r <= cycle_count_r;
                end
            end else begin
                tick_r <= {NUM_CH{1'b0}};
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.mode && bus.step_req) begin
                        state_r <= ST_STEP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    // Window closes on leaving step mode or on the channel-0 tick.
                    if (!bus.mode) begin
                        state_r <= ST_IDLE;
                    end else if (adv_s && tick_n_s[0]) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_STEP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.clk_out     = clk_out_r;
    assign bus.tick        = tick_r;
    assign bus.busy        = busy_s;
    assign bus.cycle_count = cycle_count_r;

endmodule

// File: tb/tb_clock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_clock_sequencer
// Directed test of clock_sequencer (NUM_CH=4, CNT_W=8, DEFAULT_DIV=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_clock_sequencer;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    clock_sequencer_if #(.NUM_CH(4), .CNT_W(8)) sif ();

    clock_sequencer #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    // Expected per-edge patterns for R={2,3,4,8}, P={0,2,3,7(clamped)}; bit i = channel i.
    logic [3:0] cfg_tick_t [8] = '{4'h1, 4'h0, 4'h3, 4'h4, 4'h1, 4'h2, 4'h1, 4'hC};
    logic [3:0] cfg_clk_t  [8] = '{4'hF, 4'hC, 4'h9, 4'hA, 4'h5, 4'h4, 4'h3, 4'h0};

    task automatic tick_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_cfg(input logic [31:0] r, input logic [31:0] p, input logic m);
        sif.div_ratio = r;
        sif.phase     = p;
        sif.mode      = m;
        sif.cfg_load  = 1'b1;
        tick_edge();
        sif.cfg_load  = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] et;
        logic [3:0] ec;
        reset = 1'b0;
        tick_edge();
        tick_edge();
        total++; if (sif.clk_out !== 4'h0) begin bad++; $display("FAIL reset_clk: got %h want 0", sif.clk_out); end
        total++; if (sif.tick !== 4'h0) begin bad++; $display("FAIL reset_tick: got %h want 0", sif.tick); end
        total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sif.busy); end
        total++; if (sif.cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", sif.cycle_count); end
        reset      = 1'b1;
        sif.enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick_edge();
            et = (k % 4 == 1) ? 4'hF : 4'h0;
            ec = (((k - 1) % 4) < 2) ? 4'hF : 4'h0;
            total++; if (sif.tick !== et) begin bad++; $display("FAIL run_tick e%0d: got %h want %h", k, sif.tick, et); end
            total++; if (sif.clk_out !== ec) begin bad++; $display("FAIL run_clk e%0d: got %h want %h", k, sif.clk_out, ec); end
        end
        total++; if (sif.cycle_count !== 32'd3) begin bad++; $display("FAIL run_count: got %0d want 3", sif.cycle_count); end
    endtask

    task automatic test_cfg_load();
        do_cfg({8'd8, 8'd4, 8'd3, 8'd2}, {8'd9, 8'd3, 8'd2, 8'd0}, 1'b0);
        total++; if (sif.tick !== 4'h0) begin bad++; $display("FAIL cfg_tick: got %h want 0", sif.tick); end
        total++; if (sif.clk_out !== 4'h0) begin bad++; $display("FAIL cfg_clk: got %h want 0", sif.clk_out); end
        total++; if (sif.cycle_count !== 32'd0) begin bad++; $display("FAIL cfg_count: got %0d want 0", sif.cycle_count); end
        // Config inputs must be ignored outside cfg_load.
        sif.div_ratio = 32'h0;
        sif.phase     = 32'hFFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            tick_edge();
            total++; if (sif.tick !== cfg_tick_t[k]) begin bad++; $display("FAIL cfg_tick e%0d: got %h want %h", k + 1, sif.tick, cfg_tick_t[k]); end
            total++; if (sif.clk_out !== cfg_clk_t[k]) begin bad++; $display("FAIL cfg_clk e%0d: got %h want %h", k + 1, sif.clk_out, cfg_clk_t[k]); end
        end
        total++; if (sif.cycle_count !== 32'd4) begin bad++; $display("FAIL cfg_count_end: got %0d want 4", sif.cycle_count); end
    endtask

    task automatic test_single_step();
        do_cfg(32'h0404_0404, 32'h0, 1'b0);
        tick_edge();
        total++; if (sif.tick !== 4'hF) begin bad++; $display("FAIL step_pre_tick: got %h want F", sif.tick); end
        sif.mode = 1'b1;
        tick_edge();
        total++; if (sif.tick !== 4'h0 || sif.busy !== 1'b0) begin bad++; $display("FAIL step_freeze: got tick %h busy %b want 0 0", sif.tick, sif.busy); end
        sif.step_req = 1'b1;
        tick_edge();
        total++; if (sif.busy !== 1'b1 || sif.clk_out !== 4'hF) begin bad++; $display("FAIL step_open: got busy %b clk %h want 1 F", sif.busy, sif.clk_out); end
        // step_req still high during the window: must not extend or queue.
        tick_edge();
        sif.step_req = 1'b0;
        total++; if (sif.busy !== 1'b1 || sif.tick !== 4'h0 || sif.clk_out !== 4'hF) begin bad++; $display("FAIL step_e1: got busy %b tick %h clk %h want 1 0 F", sif.busy, sif.tick, sif.clk_out); end
        for (int k = 2; k <= 3; k++) begin
            tick_edge();
            total++; if (sif.busy !== 1'b1 || sif.tick !== 4'h0 || sif.clk_out !== 4'h0) begin bad++; $display("FAIL step_e%0d: got busy %b tick %h clk %h want 1 0 0", k, sif.busy, sif.tick, sif.clk_out); end
        end
        tick_edge();
        total++; if (sif.busy !== 1'b0 || sif.tick !== 4'hF || sif.clk_out !== 4'hF) begin bad++; $display("FAIL step_e4: got busy %b tick %h clk %h want 0 F F", sif.busy, sif.tick, sif.clk_out); end
        total++; if (sif.cycle_count !== 32'd2) begin bad++; $display("FAIL step_count: got %0d want 2", sif.cycle_count); end
        for (int k = 0; k < 20; k++) begin
            tick_edge();
            total++; if (sif.busy !== 1'b0 || sif.tick !== 4'h0 || sif.clk_out !== 4'hF) begin bad++; $display("FAIL step_hold %0d: got busy %b tick %h clk %h want 0 0 F", k, sif.busy, sif.tick, sif.clk_out); end
        end
        total++; if (sif.cycle_count !== 32'd2) begin bad++; $display("FAIL step_hold_count: got %0d want 2", sif.cycle_count); end
    endtask

    task automatic test_freeze();
        do_cfg(32'h0404_0404, 32'h0, 1'b0);
        tick_edge();
        total++; if (sif.tick !== 4'hF) begin bad++; $display("FAIL frz_e1: got %h want F", sif.tick); end
        tick_edge();
        sif.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick_edge();
            total++; if (sif.tick !== 4'h0 || sif.clk_out !== 4'hF) begin bad++; $display("FAIL frz_hold %0d: got tick %h clk %h want 0 F", k, sif.tick, sif.clk_out); end
        end
        sif.enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick_edge();
            total++; if (sif.tick !== 4'h0 || sif.clk_out !== 4'h0) begin bad++; $display("FAIL frz_resume %0d: got tick %h clk %h want 0 0", k, sif.tick, sif.clk_out); end
        end
        tick_edge();
        total++; if (sif.tick !== 4'hF || sif.clk_out !== 4'hF) begin bad++; $display("FAIL frz_wrap: got tick %h clk %h want F F", sif.tick, sif.clk_out); end
        total++; if (sif.cycle_count !== 32'd2) begin bad++; $display("FAIL frz_count: got %0d want 2", sif.cycle_count); end
    endtask

    task automatic test_ratio_one();
        do_cfg({8'd4, 8'd4, 8'd1, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd5}, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick_edge();
            total++; if (sif.tick[1:0] !== 2'b11 || sif.clk_out[1:0] !== 2'b11) begin bad++; $display("FAIL r1_e%0d: got tick %b clk %b want 11 11", k, sif.tick[1:0], sif.clk_out[1:0]); end
            total++; if (sif.cycle_count !== 32'(k)) begin bad++; $display("FAIL r1_count e%0d: got %0d want %0d", k, sif.cycle_count, k); end
        end
        force dut.cycle_count_r = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_count_r;
        tick_edge();
        total++; if (sif.cycle_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL r1_max: got %h want FFFFFFFF", sif.cycle_count); end
        tick_edge();
        total++; if (sif.cycle_count !== 32'h0) begin bad++; $display("FAIL r1_wrap: got %h want 0", sif.cycle_count); end
    endtask

    task automatic test_async_reset();
        do_cfg({8'd8, 8'd4, 8'd4, 8'd4}, 32'h0, 1'b0);
        tick_edge();
        sif.mode = 1'b1;
        tick_edge();
        sif.step_req = 1'b1;
        tick_edge();
        sif.step_req = 1'b0;
        tick_edge();
        tick_edge();
        total++; if (sif.busy !== 1'b1 || sif.clk_out !== 4'h8 || sif.cycle_count !== 32'd1) begin bad++; $display("FAIL ar_pre: got busy %b clk %h cnt %0d want 1 8 1", sif.busy, sif.clk_out, sif.cycle_count); end
        #2 reset = 1'b0;
        #1;
        total++; if (sif.busy !== 1'b0 || sif.clk_out !== 4'h0 || sif.tick !== 4'h0 || sif.cycle_count !== 32'd0) begin bad++; $display("FAIL ar_now: got busy %b clk %h tick %h cnt %0d want 0 0 0 0", sif.busy, sif.clk_out, sif.tick, sif.cycle_count); end
        sif.mode = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick_edge();
            total++; if (sif.tick !== ((k == 1 || k == 5) ? 4'hF : 4'h0)) begin bad++; $display("FAIL ar_tick e%0d: got %h want %h", k, sif.tick, (k == 1 || k == 5) ? 4'hF : 4'h0); end
        end
    endtask

    initial begin
        reset         = 1'b0;
        sif.enable    = 1'b0;
        sif.mode      = 1'b0;
        sif.step_req  = 1'b0;
        sif.cfg_load  = 1'b0;
        sif.div_ratio = 32'h0;
        sif.phase     = 32'h0;
        test_reset();
        test_cfg_load();
        test_single_step();
        test_freeze();
        test_ratio_one();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_sequencer.md
Name: clock_sequencer

Overview:
- Parametrised successor to the fixed clock-divider chain at the top level.
- Generates NUM_CH independent divided clocks and one-cycle tick enables from the single master clock. Each channel has its own runtime divide ratio and phase offset.
- Adds synchronous realignment, run/freeze control, a single-step mode for debug, and a channel-0 tick counter.
- Sits beside the processor/memory wrapper. Channel 0 drives the processor; the other channels serve imem, dmem and regfile.

Parameters:
NUM_CH, 4, number of output channels (>=1)
CNT_W, 8, width of per-channel ratio/phase/counter
DEFAULT_DIV, 4, ratio loaded into every channel at reset (1..2^CNT_W-1)

Ports:
clock  in  1  master clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = counters may advance; 0 = freeze
mode  in  1  0 = free-run; 1 = single-step
step_req  in  1  single-step request (mode=1 only)
cfg_load  in  1  latch div_ratio/phase, realign all channels
div_ratio  in  NUM_CH*CNT_W  channel i ratio R_i in bits [i*CNT_W +: CNT_W]
phase  in  NUM_CH*CNT_W  channel i tick offset P_i, same packing
clk_out  out  NUM_CH  registered divided clocks
tick  out  NUM_CH  registered one-cycle enable pulses
busy  out  1  single-step window open
cycle_count  out  32  number of channel-0 ticks since reset/cfg_load

Behaviour:
- Reset (reset=0, async):
  - R_i = DEFAULT_DIV, P_i = 0, cnt_i = R_i-1.
  - clk_out = 0, tick = 0, busy = 0, cycle_count = 0.
- Latched config:
  - div_ratio field 0 is stored as 1.
  - A phase field >= R is stored as R-1.
  - Latching happens only on cfg_load; inputs are otherwise ignored.
- Advance condition: adv = enable & (mode==0 | busy). All channels advance together.
- On an advancing edge, per channel:
  - cnt_n = (cnt==R-1) ? 0 : cnt+1; cnt <= cnt_n.
  - tick <= (cnt_n==P).
  - clk_out <= (R==1) ? 1 : (cnt_n < R>>1).
  - For even R the output is 50% duty; for odd R it is high floor(R/2) of R cycles.
- On a non-advancing edge:
  - cnt and clk_out hold.
  - tick <= 0, so tick is never high for two consecutive cycles unless R==1 and advancing.
- Latency and period:
  - After reset release with R=4, P=0: the first edge gives tick=1, clk_out=1; pattern repeats every 4 edges.
  - Tick period is exactly R edges while advancing.
- cfg_load (highest priority, synchronous):
  - Latch all R_i and P_i.
  - cnt_i <= R_new-1, clk_out <= 0, tick <= 0, busy <= 0, cycle_count <= 0.
  - The next advancing edge behaves like the first edge after reset, so all channels realign phase-coherently.
- cycle_count increments (wrapping at 2^32) on every edge that sets tick[0].
- Single-step:
  - In mode=1 with busy=0 and cfg_load=0, step_req=1 sets busy<=1. Counters do not advance on that edge.
  - While busy, counters advance if enable=1.
  - The edge that sets tick[0] also clears busy. The system then freezes with tick[0] high for exactly one cycle.
  - step_req while busy is ignored (no queuing). step_req in mode=0 is ignored.
- Mode change:
  - 0->1 with busy=0 freezes on the next edge.
  - 1->0 resumes free-run; busy is cleared on that edge.
- enable=0 while busy: busy holds and the window resumes when enable returns.
- Reset mid-operation (including mid-step): immediate return to reset state, independent of clock.
- R==1: tick is high on every advancing edge (phase forced to 0) and clk_out is held 1.

Test Plan:
- Reset, R default 4, P=0, mode=0, enable=1 -> tick[all]=1 on edges 1,5,9; clk_out high on edges 1-2, low on 3-4; cycle_count=3 after edge 9.
- cfg_load with R={2,3,4,8}, P={0,2,3,9} -> P3 stored 7; tick0 every 2 edges at edges 1,3; tick1 at edges 3,6; tick2 at edge 4; tick3 at edge 8; clk_out1 high 1 of 3 edges; cycle_count cleared.
- mode=1, R0=4, single step_req pulse -> busy=1 next cycle; exactly 4 advancing edges; tick[0] high one cycle as busy falls; counters frozen for 20 further cycles; second step_req during busy ignored.
- enable=0 for 5 cycles mid-period with R=4 -> cnt and clk_out hold, tick=0 throughout; period resumes without losing or adding counts.
- div_ratio field 0 and 1 -> stored R=1; tick and clk_out constantly 1 while advancing; cycle_count increments every edge and wraps 0xFFFFFFFF->0 (preload via long run or force).
- Async reset asserted mid-step with busy=1 and cnt=2 -> all outputs 0 and busy 0 immediately without a clock edge; R restored to DEFAULT_DIV.
